// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: instruction memory port, decode redirects, IF/ID outputs
interface fetch_stage_if;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic        halted;
    logic        fetch_error;

    modport master (
        output pc_out, ifid_instr, ifid_pc_plus1, ifid_valid, halted, fetch_error,
        input  instr_in, stall, branch_taken, branch_offset, jump, jump_index, jr, jr_target
    );

    modport slave (
        input  pc_out, ifid_instr, ifid_pc_plus1, ifid_valid, halted, fetch_error,
        output instr_in, stall, branch_taken, branch_offset, jump, jump_index, jr, jr_target
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter and IF/ID register with redirect, stall, halt and range error
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] IMEM_DEPTH = 32'd32,
    parameter logic [31:0] HALT_INSTR = 32'hFC000000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HALT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ifid_instr, ifid_instr_n;
    logic [31:0] ifid_pc_plus1, ifid_pc_plus1_n;
    logic        ifid_valid, ifid_valid_n;
    logic        halted, halted_n;
    logic        fetch_error, fetch_error_n;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus1;

    assign pc_plus1 = pc + 32'd1;

    // Redirects come from the instruction sitting in IF/ID, so a squashed slot cannot redirect.
    assign redirect = ifid_valid & (bus.jr | bus.jump | bus.branch_taken);

    always_comb begin
        target = ifid_pc_plus1 + {{16{bus.branch_offset[15]}}, bus.branch_offset};
        if (bus.jr) begin
            target = bus.jr_target;
        end else if (bus.jump) begin
            target = {ifid_pc_plus1[31:26], bus.jump_index};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            ifid_instr    <= 32'd0;
            ifid_pc_plus1 <= 32'd0;
            ifid_valid    <= 1'b0;
            halted        <= 1'b0;
            fetch_error   <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            ifid_instr    <= ifid_instr_n;
            ifid_pc_plus1 <= ifid_pc_plus1_n;
            ifid_valid    <= ifid_valid_n;
            halted        <= halted_n;
            fetch_error   <= fetch_error_n;
        end
    end

    always_comb begin
        state_n         = state;
        pc_n            = pc;
        ifid_instr_n    = ifid_instr;
        ifid_pc_plus1_n = ifid_pc_plus1;
        ifid_valid_n    = 1'b0;

        case (state)
            S_FETCH: begin
                ifid_valid_n = ifid_valid;
                if (redirect) begin
                    pc_n         = target;
                    ifid_valid_n = 1'b0;
                end else if (bus.stall) begin
                    ifid_valid_n = ifid_valid;
                end else if (pc >= IMEM_DEPTH) begin
                    state_n      = S_ERROR;
                    ifid_valid_n = 1'b0;
                end else if (bus.instr_in == HALT_INSTR) begin
                    state_n      = S_HALT;
                    ifid_valid_n = 1'b0;
                end else begin
                    ifid_instr_n    = bus.instr_in;
                    ifid_pc_plus1_n = pc_plus1;
                    ifid_valid_n    = 1'b1;
                    pc_n            = pc_plus1;
                end
            end
            default: begin
                ifid_valid_n = 1'b0;
            end
        endcase

        halted_n      = (state_n == S_HALT);
        fetch_error_n = (state_n == S_ERROR);
    end

    assign bus.pc_out        = pc;
    assign bus.ifid_instr    = ifid_instr;
    assign bus.ifid_pc_plus1 = ifid_pc_plus1;
    assign bus.ifid_valid    = ifid_valid;
    assign bus.halted        = halted;
    assign bus.fetch_error   = fetch_error;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] HALT_W = 32'hFC000000;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pp1;
        logic        h;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cycle_no = 0;
    bit   done = 1'b0;

    exp_t        sb[$];
    logic [31:0] mem [0:63];

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC  (32'd0),
        .IMEM_DEPTH(32'd32),
        .HALT_INSTR(HALT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = (bus.pc_out < 32'd64) ? mem[bus.pc_out[5:0]] : 32'd0;

    function automatic logic [31:0] w(input int k);
        return 32'hA5000000 + k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle_no, act, exp);
        end
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("pc_out",        bus.pc_out,             e.pc);
                chk("ifid_valid",    {31'd0, bus.ifid_valid}, {31'd0, e.v});
                chk("ifid_instr",    bus.ifid_instr,         e.instr);
                chk("ifid_pc_plus1", bus.ifid_pc_plus1,      e.pp1);
                chk("halted",        {31'd0, bus.halted},     {31'd0, e.h});
                chk("fetch_error",   {31'd0, bus.fetch_error}, {31'd0, e.e});
            end
        end
    end

    task automatic idle();
        reset              = 1'b0;
        bus.stall          = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_offset  = 16'd0;
        bus.jump           = 1'b0;
        bus.jump_index     = 26'd0;
        bus.jr             = 1'b0;
        bus.jr_target      = 32'd0;
    endtask

    // Inputs are already driven; push the state expected after the next edge and advance.
    task automatic cyc(input logic [31:0] pc, input logic v, input logic [31:0] instr,
                       input logic [31:0] pp1, input logic h, input logic e);
        exp_t x;
        x.pc = pc; x.v = v; x.instr = instr; x.pp1 = pp1; x.h = h; x.e = e;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = w(k);
        idle();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Sequential fetch, stall, branch bubble
        idle();
        cyc(1, 1, w(0), 1, 0, 0);
        cyc(2, 1, w(1), 2, 0, 0);
        bus.stall = 1'b1;
        cyc(2, 1, w(1), 2, 0, 0);
        cyc(2, 1, w(1), 2, 0, 0);
        idle();
        cyc(3, 1, w(2), 3, 0, 0);
        cyc(4, 1, w(3), 4, 0, 0);
        cyc(5, 1, w(4), 5, 0, 0);
        bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFE;
        cyc(3, 0, w(4), 5, 0, 0);
        idle();
        cyc(4, 1, w(3), 4, 0, 0);

        // jr beats jump and branch and overrides stall; ignored once ifid_valid is 0
        bus.stall = 1'b1;
        bus.jr = 1'b1; bus.jr_target = 32'd9;
        bus.jump = 1'b1; bus.jump_index = 26'h15;
        bus.branch_taken = 1'b1; bus.branch_offset = 16'd7;
        cyc(9, 0, w(3), 4, 0, 0);
        cyc(9, 0, w(3), 4, 0, 0);
        bus.stall = 1'b0;
        cyc(10, 1, w(9), 10, 0, 0);

        // jump beats branch
        idle();
        bus.jump = 1'b1; bus.jump_index = 26'h1C;
        bus.branch_taken = 1'b1; bus.branch_offset = 16'd1;
        cyc(28, 0, w(9), 10, 0, 0);
        idle();
        cyc(29, 1, w(28), 29, 0, 0);

        // Halt word at index 4
        mem[4] = HALT_W;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        idle();
        cyc(1, 1, w(0), 1, 0, 0);
        cyc(2, 1, w(1), 2, 0, 0);
        cyc(3, 1, w(2), 3, 0, 0);
        cyc(4, 1, w(3), 4, 0, 0);
        cyc(4, 0, w(3), 4, 1, 0);
        bus.jr = 1'b1; bus.jr_target = 32'd9; bus.stall = 1'b1;
        cyc(4, 0, w(3), 4, 1, 0);
        idle();
        cyc(4, 0, w(3), 4, 1, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Out-of-range PC via jr
        idle();
        cyc(1, 1, w(0), 1, 0, 0);
        bus.jr = 1'b1; bus.jr_target = 32'd32;
        cyc(32, 0, w(0), 1, 0, 0);
        idle();
        cyc(32, 0, w(0), 1, 0, 1);
        bus.stall = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'd3;
        cyc(32, 0, w(0), 1, 0, 1);
        idle();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Reset during a stall in FETCH
        idle();
        cyc(1, 1, w(0), 1, 0, 0);
        bus.stall = 1'b1;
        cyc(1, 1, w(0), 1, 0, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        idle();
        cyc(1, 1, w(0), 1, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
